// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: free-running x/y counters with registered sync, active-video and ticks.
// Optional macro SYNC_DELAY_EN adds a DLY_CYC-stage pix_ce-qualified delay line on the _d outputs.
module vga_timing_gen #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned DLY_CYC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       video_on_d
);

  localparam int unsigned HTotal = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HMax     = 10'(HTotal - 1);
  localparam logic [9:0] VMax     = 10'(VTotal - 1);
  localparam logic [9:0] HAct     = 10'(H_ACT);
  localparam logic [9:0] VAct     = 10'(V_ACT);
  localparam logic [9:0] HsStart  = 10'(H_ACT + H_FP);
  localparam logic [9:0] HsEnd    = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VsStart  = 10'(V_ACT + V_FP);
  localparam logic [9:0] VsEnd    = 10'(V_ACT + V_FP + V_SYNC);
  localparam logic       SyncOn   = SYNC_POL;
  localparam logic       SyncOff  = ~SYNC_POL;

  if (HTotal > 1024 || VTotal > 1024 || DLY_CYC < 1 || DLY_CYC > 8) begin : gen_param_check
    $error("vga_timing_gen: illegal timing or delay parameters");
  end

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_nx;
  logic       vsync_q, vsync_nx;
  logic       video_on_q, video_on_nx;
  logic       line_tick_q, frame_tick_q;

  // Decode from next-count values so registered sync/video line up with the registered counts.
  always_comb begin
    x_d = (x_q == HMax) ? 10'd0 : x_q + 10'd1;
    y_d = y_q;
    if (x_q == HMax) begin
      y_d = (y_q == VMax) ? 10'd0 : y_q + 10'd1;
    end
    hsync_nx    = ((x_d >= HsStart) && (x_d < HsEnd)) ? SyncOn : SyncOff;
    vsync_nx    = ((y_d >= VsStart) && (y_d < VsEnd)) ? SyncOn : SyncOff;
    video_on_nx = (x_d < HAct) && (y_d < VAct);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q          <= HMax;
      y_q          <= VMax;
      hsync_q      <= SyncOff;
      vsync_q      <= SyncOff;
      video_on_q   <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else if (pix_ce) begin
      x_q          <= x_d;
      y_q          <= y_d;
      hsync_q      <= hsync_nx;
      vsync_q      <= vsync_nx;
      video_on_q   <= video_on_nx;
      line_tick_q  <= (x_d == 10'd0);
      frame_tick_q <= (x_d == 10'd0) && (y_d == 10'd0);
    end else begin
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end
  end

  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

`ifdef SYNC_DELAY_EN
  logic [DLY_CYC-1:0] hs_pipe_q, vs_pipe_q, vo_pipe_q;

  // Stage 0 captures the registered outputs, so hsync_d trails hsync by exactly DLY_CYC advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_pipe_q <= {DLY_CYC{SyncOff}};
      vs_pipe_q <= {DLY_CYC{SyncOff}};
      vo_pipe_q <= '0;
    end else if (pix_ce) begin
      hs_pipe_q[0] <= hsync_q;
      vs_pipe_q[0] <= vsync_q;
      vo_pipe_q[0] <= video_on_q;
      for (int i = 1; i < DLY_CYC; i++) begin
        hs_pipe_q[i] <= hs_pipe_q[i-1];
        vs_pipe_q[i] <= vs_pipe_q[i-1];
        vo_pipe_q[i] <= vo_pipe_q[i-1];
      end
    end
  end

  assign hsync_d    = hs_pipe_q[DLY_CYC-1];
  assign vsync_d    = vs_pipe_q[DLY_CYC-1];
  assign video_on_d = vo_pipe_q[DLY_CYC-1];
`else
  assign hsync_d    = hsync_q;
  assign vsync_d    = vsync_q;
  assign video_on_d = video_on_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 640x480 instance for line-level timing, plus a
// reduced 16x12 active-high instance for whole-frame and pix_ce-gated behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a, ce_a, rst_b, ce_b;
  logic [9:0] ax, ay, bx, by;
  logic a_hs, a_vs, a_vo, a_lt, a_ft, a_hsd, a_vsd, a_vod;
  logic b_hs, b_vs, b_vo, b_lt, b_ft, b_hsd, b_vsd, b_vod;

  vga_timing_gen u_dut_a (
    .clk(clk), .reset(rst_a), .pix_ce(ce_a), .pix_x(ax), .pix_y(ay),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .line_tick(a_lt), .frame_tick(a_ft),
    .hsync_d(a_hsd), .vsync_d(a_vsd), .video_on_d(a_vod)
  );

  // 16 px/line (act 8, fp 2, sync 3, bp 3), 12 lines/frame (act 6, fp 2, sync 2, bp 2)
  vga_timing_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .pix_ce(ce_b), .pix_x(bx), .pix_y(by),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .line_tick(b_lt), .frame_tick(b_ft),
    .hsync_d(b_hsd), .vsync_d(b_vsd), .video_on_d(b_vod)
  );

  task automatic step_a(input logic ce);
    ce_a = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic ce);
    ce_b = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b0;
    ce_a  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({ax, ay, a_vo, a_hs, a_vs, a_lt, a_ft} !== {10'd799, 10'd524, 5'b01100}) begin
      errors++;
      $display("FAIL reset_state: got x=%0d y=%0d vo/hs/vs/lt/ft=%b%b%b%b%b want 799 524 01100",
               ax, ay, a_vo, a_hs, a_vs, a_lt, a_ft);
    end
    checks++;
    if ({a_hsd, a_vsd, a_vod} !== 3'b110) begin
      errors++;
      $display("FAIL reset_delayed: got hsd/vsd/vod=%b%b%b want 110", a_hsd, a_vsd, a_vod);
    end
    rst_a = 1'b1;
    #1;
    checks++;
    if ({ax, ay} !== {10'd799, 10'd524}) begin
      errors++;
      $display("FAIL release_hold: got x=%0d y=%0d want 799 524", ax, ay);
    end
    step_a(1'b1);
    checks++;
    if ({ax, ay, a_vo, a_lt, a_ft, a_hs, a_vs} !== {10'd0, 10'd0, 5'b11111}) begin
      errors++;
      $display("FAIL first_advance: got x=%0d y=%0d vo/lt/ft/hs/vs=%b%b%b%b%b want 0 0 11111",
               ax, ay, a_vo, a_lt, a_ft, a_hs, a_vs);
    end
    step_a(1'b1);
    checks++;
    if ({ax, ay, a_vo, a_lt, a_ft} !== {10'd1, 10'd0, 3'b100}) begin
      errors++;
      $display("FAIL tick_width: got x=%0d y=%0d vo/lt/ft=%b%b%b want 1 0 100",
               ax, ay, a_vo, a_lt, a_ft);
    end
  endtask

  // Walk the rest of line 0 from x=1 to x=799, then cross into line 1.
  task automatic test_hsync;
    int   low = 0, first = -1, last = -1, vs_bad = 0, d_bad = 0;
    logic vo639 = 1'b0, vo640 = 1'b1;
    for (int i = 0; i < 798; i++) begin
      step_a(1'b1);
      if (a_hs == 1'b0) begin
        low++;
        if (first < 0) first = int'(ax);
        last = int'(ax);
      end
      if (a_vs !== 1'b1) vs_bad++;
      if (ax == 10'd639) vo639 = a_vo;
      if (ax == 10'd640) vo640 = a_vo;
      if ({a_hsd, a_vsd, a_vod} !== {a_hs, a_vs, a_vo}) d_bad++;
    end
    checks++;
    if (ax !== 10'd799) begin
      errors++; $display("FAIL line_end: got x=%0d want 799", ax);
    end
    checks++;
    if (low != 96) begin
      errors++; $display("FAIL hsync_width: got %0d want 96", low);
    end
    checks++;
    if (first != 656 || last != 751) begin
      errors++; $display("FAIL hsync_span: got %0d..%0d want 656..751", first, last);
    end
    checks++;
    if ({vo639, vo640} !== 2'b10) begin
      errors++; $display("FAIL video_edge: got vo@639/640=%b%b want 10", vo639, vo640);
    end
    checks++;
    if (vs_bad != 0) begin
      errors++; $display("FAIL vsync_line0: got %0d active cycles want 0", vs_bad);
    end
`ifndef SYNC_DELAY_EN
    checks++;
    if (d_bad != 0) begin
      errors++; $display("FAIL d_passthru: got %0d differing cycles want 0", d_bad);
    end
`endif
    step_a(1'b1);
    checks++;
    if ({ax, ay, a_lt, a_ft} !== {10'd0, 10'd1, 2'b10}) begin
      errors++;
      $display("FAIL h_wrap: got x=%0d y=%0d lt/ft=%b%b want 0 1 10", ax, ay, a_lt, a_ft);
    end
  endtask

  task automatic test_delay;
`ifdef SYNC_DELAY_EN
    int   hs_fall = -1, hsd_fall = -1;
    logic prev_hs = a_hs, prev_hsd = a_hsd;
    for (int i = 0; i < 800; i++) begin
      step_a(1'b1);
      if (prev_hs && !a_hs && hs_fall < 0) hs_fall = i;
      if (prev_hsd && !a_hsd && hsd_fall < 0) hsd_fall = i;
      prev_hs  = a_hs;
      prev_hsd = a_hsd;
    end
    checks++;
    if (hs_fall < 0 || hsd_fall - hs_fall != 2) begin
      errors++;
      $display("FAIL hsync_d_delay: got hs fall %0d hsd fall %0d want gap 2", hs_fall, hsd_fall);
    end
`else
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      step_a(i[0]);
      if ({a_hsd, a_vsd, a_vod} !== {a_hs, a_vs, a_vo}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL d_passthru_ce: got %0d differing cycles want 0", bad);
    end
`endif
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (ax == 10'd300 && ay == 10'd2) found = 1'b1;
      else step_a(1'b1);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_300_2: got x=%0d y=%0d want 300 2", ax, ay);
    end
    #2 rst_a = 1'b0;
    #1;
    checks++;
    if ({ax, ay, a_vo, a_hs, a_vs, a_lt, a_ft, a_vod} !== {10'd799, 10'd524, 6'b011000}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d vo/hs/vs/lt/ft/vod=%b%b%b%b%b%b want 799 524 011000",
               ax, ay, a_vo, a_hs, a_vs, a_lt, a_ft, a_vod);
    end
    step_a(1'b1);
    step_a(1'b1);
    checks++;
    if ({ax, ay} !== {10'd799, 10'd524}) begin
      errors++; $display("FAIL reset_hold: got x=%0d y=%0d want 799 524", ax, ay);
    end
    rst_a = 1'b1;
    step_a(1'b1);
    checks++;
    if ({ax, ay, a_ft, a_vo} !== {10'd0, 10'd0, 2'b11}) begin
      errors++;
      $display("FAIL restart: got x=%0d y=%0d ft/vo=%b%b want 0 0 11", ax, ay, a_ft, a_vo);
    end
  endtask

  task automatic test_frame;
    int n_ft = 0, last_ft = 0, per_bad = 0, vs_cnt = 0, vs_bad = 0, hs_bad = 0;
    int refs = 0, n_lt = 0;
    logic hs_exp;
    rst_b = 1'b0;
    ce_b  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bx, by, b_hs, b_vs, b_vo} !== {10'd15, 10'd11, 3'b000}) begin
      errors++;
      $display("FAIL small_reset: got x=%0d y=%0d hs/vs/vo=%b%b%b want 15 11 000",
               bx, by, b_hs, b_vs, b_vo);
    end
    rst_b = 1'b1;
    step_b(1'b1);
    checks++;
    if ({bx, by, b_lt, b_ft, b_vo} !== {10'd0, 10'd0, 3'b111}) begin
      errors++;
      $display("FAIL small_first: got x=%0d y=%0d lt/ft/vo=%b%b%b want 0 0 111",
               bx, by, b_lt, b_ft, b_vo);
    end
    for (int i = 1; i <= 384; i++) begin
      step_b(1'b1);
      if (b_ft) begin
        n_ft++;
        if (i - last_ft != 192) per_bad++;
        last_ft = i;
      end
      if (b_lt) n_lt++;
      if (b_vs) begin
        vs_cnt++;
        if (by != 10'd8 && by != 10'd9) vs_bad++;
      end
      hs_exp = (bx >= 10'd10 && bx <= 10'd12);
      if (b_hs !== hs_exp) hs_bad++;
      if (bx == 10'd0 && by == 10'd7) refs++;
    end
    checks++;
    if (n_ft != 2 || per_bad != 0) begin
      errors++; $display("FAIL frame_period: got %0d ticks %0d bad gaps want 2 0", n_ft, per_bad);
    end
    checks++;
    if (n_lt != 24) begin
      errors++; $display("FAIL line_ticks: got %0d want 24", n_lt);
    end
    checks++;
    if (vs_cnt != 64 || vs_bad != 0) begin
      errors++; $display("FAIL vsync_frame: got %0d cycles %0d misplaced want 64 0", vs_cnt, vs_bad);
    end
    checks++;
    if (hs_bad != 0) begin
      errors++; $display("FAIL hsync_pol: got %0d wrong cycles want 0", hs_bad);
    end
    checks++;
    if (refs != 2) begin
      errors++; $display("FAIL refresh_point: got %0d want 2", refs);
    end
  endtask

  task automatic test_ce_gated;
    int   ex = 15, ey = 11, pos_bad = 0, hold_bad = 0, tick_bad = 0, n_ft = 0, last_ft = 0;
    int   per_bad = 0;
    logic ce, exp_lt, exp_ft, p_hs, p_vs, p_vo;
    rst_b = 1'b0;
    ce_b  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    for (int i = 0; i <= 1536; i++) begin
      ce = (i % 4 == 0);
      p_hs = b_hs; p_vs = b_vs; p_vo = b_vo;
      exp_lt = 1'b0; exp_ft = 1'b0;
      if (ce) begin
        if (ex == 15) begin
          ex = 0;
          ey = (ey == 11) ? 0 : ey + 1;
        end else begin
          ex++;
        end
        exp_lt = (ex == 0);
        exp_ft = (ex == 0 && ey == 0);
      end
      step_b(ce);
      if (int'(bx) != ex || int'(by) != ey) pos_bad++;
      if (!ce && {b_hs, b_vs, b_vo} !== {p_hs, p_vs, p_vo}) hold_bad++;
      if ({b_lt, b_ft} !== {exp_lt, exp_ft}) tick_bad++;
      if (b_ft) begin
        if (n_ft > 0 && i - last_ft != 768) per_bad++;
        n_ft++;
        last_ft = i;
      end
    end
    checks++;
    if (pos_bad != 0) begin
      errors++; $display("FAIL ce_counts: got %0d wrong positions want 0", pos_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL ce_hold: got %0d changed outputs on idle cycles want 0", hold_bad);
    end
    checks++;
    if (tick_bad != 0) begin
      errors++; $display("FAIL ce_ticks: got %0d wrong tick cycles want 0", tick_bad);
    end
    checks++;
    if (n_ft != 3 || per_bad != 0) begin
      errors++; $display("FAIL ce_frame_period: got %0d ticks %0d bad gaps want 3 0", n_ft, per_bad);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ce_a  = 1'b0;
    ce_b  = 1'b0;
    test_reset;
    test_hsync;
    test_delay;
    test_reset_mid;
    test_frame;
    test_ce_gated;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
